// File: rtl/handshake_sender_pkg.sv
// Shared types for the req/ack source-side handshake.
// Sync depth helper clamps to the minimum safe chain length.
package handshake_sender_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int SYNC_MIN = 2;

  function automatic int sync_depth(input int n);
    return (n < SYNC_MIN) ? SYNC_MIN : n;
  endfunction

endpackage

// File: rtl/handshake_sender_ack_sync.sv
// N-stage single-bit synchronizer with async active-low clear.
// Generalised form of the two-stage receiver synchronizer.
module ack_sync_chain
  import handshake_sender_pkg::*;
#(
  parameter int STAGES = SYNC_MIN
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/handshake_sender.sv
// Source half of a 4-phase req/ack CDC handshake.
// Optional abort timer enabled by HANDSHAKE_TIMEOUT_EN.
module handshake_sender
  import handshake_sender_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ACK_SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  send_valid,
  input  logic [DATA_WIDTH-1:0] send_data,
  output logic                  send_ready,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  done_pulse
`ifdef HANDSHAKE_TIMEOUT_EN
  ,
  output logic                  timeout_pulse
`endif
);

  localparam int STAGES = sync_depth(ACK_SYNC_STAGES);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   w_data_nxt;
  logic                    r_req;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    w_ack_s;
  logic                    w_primed;

  ack_sync_chain #(.STAGES(STAGES)) u_ack_sync (
    .clock (clock),
    .reset (reset),
    .d     (ack_in),
    .q     (w_ack_s)
  );

  // Holds off acceptance until the ack chain reflects real ack_in samples.
  ack_sync_chain #(.STAGES(STAGES)) u_prime (
    .clock (clock),
    .reset (reset),
    .d     (1'b1),
    .q     (w_primed)
  );

  assign send_ready = reset & w_primed & ~w_ack_s
                    & (r_state == IDLE);

`ifdef HANDSHAKE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_tout;
  logic          w_tout_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (send_valid && send_ready) begin
          w_data_nxt  = send_data;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_ack_s) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (!w_ack_s) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef HANDSHAKE_TIMEOUT_EN
    w_tout_nxt = 1'b0;
    if (r_state != IDLE && r_cnt == TLIM) begin
      w_state_nxt = IDLE;
      w_done_nxt  = 1'b0;
      w_tout_nxt  = 1'b1;
    end
    if (w_state_nxt != r_state || r_state == IDLE) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_req   <= (w_state_nxt == REQ);
      r_done  <= w_done_nxt;
    end
  end

`ifdef HANDSHAKE_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_tout <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tout <= w_tout_nxt;
    end
  end

  assign timeout_pulse = r_tout;
`endif

  assign req_out    = r_req;
  assign data_out   = r_data;
  assign done_pulse = r_done;

endmodule

// File: doc/handshake_sender.md
Name: handshake_sender

Overview:
- Source-side half of a 4-phase req/ack clock-domain-crossing handshake.
- Accepts one data word per transfer on a valid/ready interface and holds it stable on data_out.
- Drives a level req_out toward a destination domain.
- Synchronizes the returning ack_in internally, using a 2+ flop chain, before acting on it. The destination end is built from the team's existing single-bit synchronizer.

Parameters:
- DATA_WIDTH, 8, width of transferred word.
- ACK_SYNC_STAGES, 2, flop stages on ack_in; minimum 2.
- TIMEOUT_CYCLES, 1024, abort threshold; used only when HANDSHAKE_TIMEOUT_EN is defined.

Ports:
- clock  input  1  single clock of the source domain.
- reset  input  1  asynchronous, active-low reset: asserted when 0, deassertion synchronous to clock.
- send_valid  input  1  word available on send_data.
- send_data  input  DATA_WIDTH  word to transfer.
- send_ready  output  1  sender can accept a word this cycle.
- req_out  output  1  registered request level to the destination domain.
- data_out  output  DATA_WIDTH  registered held word; stable whenever req_out=1.
- ack_in  input  1  asynchronous acknowledge from the destination domain.
- done_pulse  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - state=IDLE, req_out=0, data_out=0, done_pulse=0.
  - All ack synchronizer flops are cleared to 0.
  - send_ready=0 while reset=0.
- States: IDLE, REQ, DROP.
- IDLE:
  - send_ready = 1 only when synced ack = 0; otherwise send_ready = 0 (stale ack from an aborted transfer).
  - If send_valid & send_ready: latch send_data into data_out, then enter REQ.
  - req_out rises on the clock edge after acceptance (1-cycle latency).
- REQ:
  - req_out=1 and data_out frozen.
  - When synced ack = 1, enter DROP; req_out falls on that same edge.
- DROP:
  - req_out=0; data_out is still held.
  - When synced ack = 0, enter IDLE and assert done_pulse for exactly 1 cycle.
  - send_ready may be 1 in the cycle done_pulse is high, allowing back-to-back transfers.
- Ack path:
  - ack_in passes through ACK_SYNC_STAGES flops.
  - An ack edge at ack_in is visible to the FSM ACK_SYNC_STAGES cycles later.
- Ignored inputs:
  - send_valid/send_data are ignored outside IDLE.
  - ack glitches shorter than the sync chain are not filtered; the protocol guarantees a level ack.
- Minimum transfer time: 1 + 2×ACK_SYNC_STAGES source cycles plus destination latency.
- Reset mid-transfer: req_out drops immediately and asynchronously and data_out clears. After release, the block waits in IDLE with send_ready=0 until synced ack=0.
- req_out is driven directly from a flop; no combinational logic on the crossing signal.

Optional Feature:
- Macro: HANDSHAKE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in REQ and DROP.
  - On reaching TIMEOUT_CYCLES: req_out=0, return to IDLE, pulse extra output timeout_pulse for 1 cycle; done_pulse is not asserted.
  - The counter clears on each state change.
- Undefined: no counter and no timeout_pulse port; the FSM waits indefinitely.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE=2'd0, REQ=2'd1, DROP=2'd2);
  - minimum sync stage constant (2).
- One sub-module: ack_sync_chain, a parameterised N-stage flop chain with asynchronous active-low clear.
  - It is the generalised counterpart of the existing two-stage receiver synchronizer.

Test Plan:
- Reset release, ack_in=0, send_valid=1, send_data=8'hA5:
  - send_ready=1, req_out=1 next cycle, data_out=8'hA5.
  - With an ack responder of 3-cycle delay: done_pulse once, req_out=0 at end.
- Two words 8'h11 then 8'h22 presented back-to-back:
  - second accepted no earlier than the done_pulse cycle of the first;
  - data_out never changes while req_out=1.
- Change send_data to 8'hFF during REQ:
  - data_out stays 8'h11 until IDLE and next acceptance.
- ack_in held 1 at reset release:
  - send_ready=0 until 2 cycles after ack_in drops; no transfer starts.
- reset pulsed low mid-REQ:
  - req_out=0 and data_out=0 within the same cycle, without a clock edge.
- HANDSHAKE_TIMEOUT_EN with TIMEOUT_CYCLES=16, ack_in stuck 0:
  - timeout_pulse after 16 cycles in REQ, req_out=0, send_ready=1, no done_pulse.
